mvp_sched: RTL and testbench

- Sequencer for the bit-serial mvp array: walks weight bit-planes, 2-bit activation chunks and input tiles.
- Per step it issues weight/data memory addresses and the mvp mode, then, LAT cycles later, tells the row accumulators to clear, shift and add the returned S.
- Sits between the job front-end (start/done handshake) and the weight/data buffers plus accumulator bank.

---
 rtl/mvp_sched.sv | 174 +++++++++++++++++
 tb/tb_mvp_sched.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mvp_sched.sv
// Step sequencer for the bit-serial mvp array: walks tiles, weight bit-planes and 2-bit
// activation chunks, issues buffer addresses and replays accumulator controls LAT cycles later.
module mvp_sched #(
    parameter int AW  = 10,
    parameter int LAT = 2,
    parameter int PW  = 4,
    parameter int TW  = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [PW-1:0]   wp,
    input  logic [PW-1:0]   ap,
    input  logic [TW-1:0]   tiles,
    input  logic            wsigned,
    input  logic            asigned,
    input  logic [AW-1:0]   w_base,
    input  logic [AW-1:0]   d_base,
    input  logic            stall,
    output logic            busy,
    output logic            done,
    output logic            issue,
    output logic [AW-1:0]   w_addr,
    output logic [AW-1:0]   d_addr,
    output logic [1:0]      mode,
    output logic            acc_en,
    output logic            acc_clr,
    output logic [2*PW:0]   acc_shift
);

    localparam int SW = 2 * PW + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [PW-1:0]     wp_q, ap_q;
    logic [TW-1:0]     tiles_q;
    logic              wsigned_q, asigned_q;
    logic [AW-1:0]     w_base_q, d_base_q;
    logic [TW-1:0]     k_q, k_d;
    logic [PW-1:0]     wi_q, wi_d, aj_q, aj_d;
    logic [AW-1:0]     woff_q, woff_d, doff_q, doff_d;

    logic [LAT-1:0]          vld_q, first_q;
    logic [LAT-1:0][SW-1:0]  shift_q;

    logic              issue_c, last_c, first_c, pend_c, zero_job_c;
    logic              wi_top_c, aj_top_c;
    logic [SW-1:0]     shift_c;

    assign wi_top_c   = (wi_q == wp_q - PW'(1));
    assign aj_top_c   = (aj_q == ap_q - PW'(1));
    assign issue_c    = (state_q == S_RUN) && !stall;
    assign last_c     = (k_q == tiles_q - TW'(1)) && (wi_q == '0) && (aj_q == '0);
    assign first_c    = (k_q == '0) && wi_top_c && aj_top_c;
    assign shift_c    = SW'(wi_q) + SW'({aj_q, 1'b0});
    assign zero_job_c = (wp == '0) || (ap == '0) || (tiles == '0);

    // Only entries still short of the output tap keep DRAIN waiting; the tap itself
    // drains during the cycle that DONE is entered on.
    always_comb begin
        pend_c = 1'b0;
        for (int i = 0; i < LAT - 1; i++) begin
            pend_c = pend_c | vld_q[i];
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        wi_d    = wi_q;
        aj_d    = aj_q;
        woff_d  = woff_q;
        doff_d  = doff_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = zero_job_c ? S_DONE : S_RUN;
                    k_d     = '0;
                    wi_d    = wp - PW'(1);
                    aj_d    = ap - PW'(1);
                    woff_d  = '0;
                    doff_d  = '0;
                end
            end
            S_RUN: begin
                if (issue_c) begin
                    if (last_c) begin
                        state_d = S_DRAIN;
                    end else if (aj_q != '0) begin
                        aj_d = aj_q - PW'(1);
                    end else begin
                        aj_d = ap_q - PW'(1);
                        if (wi_q != '0) begin
                            wi_d = wi_q - PW'(1);
                        end else begin
                            wi_d   = wp_q - PW'(1);
                            k_d    = k_q + TW'(1);
                            woff_d = woff_q + AW'(wp_q);
                            doff_d = doff_q + AW'(ap_q);
                        end
                    end
                end
            end
            S_DRAIN: begin
                if (!pend_c) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            wp_q      <= '0;
            ap_q      <= '0;
            tiles_q   <= '0;
            wsigned_q <= 1'b0;
            asigned_q <= 1'b0;
            w_base_q  <= '0;
            d_base_q  <= '0;
            k_q       <= '0;
            wi_q      <= '0;
            aj_q      <= '0;
            woff_q    <= '0;
            doff_q    <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            wi_q    <= wi_d;
            aj_q    <= aj_d;
            woff_q  <= woff_d;
            doff_q  <= doff_d;
            if (state_q == S_IDLE && start) begin
                wp_q      <= wp;
                ap_q      <= ap;
                tiles_q   <= tiles;
                wsigned_q <= wsigned;
                asigned_q <= asigned;
                w_base_q  <= w_base;
                d_base_q  <= d_base;
            end
        end
    end

    // Delay line matching the mvp latency; stalls and idle cycles shift in empty slots.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q   <= '0;
            first_q <= '0;
            shift_q <= '0;
        end else begin
            for (int i = LAT - 1; i > 0; i--) begin
                vld_q[i]   <= vld_q[i-1];
                first_q[i] <= first_q[i-1];
                shift_q[i] <= shift_q[i-1];
            end
            vld_q[0]   <= issue_c;
            first_q[0] <= issue_c & first_c;
            shift_q[0] <= issue_c ? shift_c : '0;
        end
    end

    assign busy      = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done      = (state_q == S_DONE);
    assign issue     = issue_c;
    assign w_addr    = issue_c ? (w_base_q + woff_q + AW'(wi_q)) : '0;
    assign d_addr    = issue_c ? (d_base_q + doff_q + AW'(aj_q)) : '0;
    assign mode      = issue_c ? {wsigned_q & wi_top_c, asigned_q & aj_top_c} : 2'b00;
    assign acc_en    = vld_q[LAT-1];
    assign acc_clr   = vld_q[LAT-1] & first_q[LAT-1];
    assign acc_shift = shift_q[LAT-1];

endmodule

// File: tb/tb_mvp_sched.sv
// Scoreboard bench for mvp_sched: a loop-nest model queues expected issues and
// accumulator events; a negedge monitor pops and compares them as the DUT emits.
module tb_mvp_sched;
    localparam int AW  = 10;
    localparam int LAT = 2;
    localparam int PW  = 4;
    localparam int TW  = 8;
    localparam int SW  = 2 * PW + 1;

    logic           clk, rst_n, start, wsigned, asigned, stall;
    logic [PW-1:0]  wp, ap;
    logic [TW-1:0]  tiles;
    logic [AW-1:0]  w_base, d_base;
    logic           busy, done, issue, acc_en, acc_clr;
    logic [AW-1:0]  w_addr, d_addr;
    logic [1:0]     mode;
    logic [SW-1:0]  acc_shift;

    mvp_sched #(.AW(AW), .LAT(LAT), .PW(PW), .TW(TW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .wp(wp), .ap(ap), .tiles(tiles),
        .wsigned(wsigned), .asigned(asigned), .w_base(w_base), .d_base(d_base),
        .stall(stall), .busy(busy), .done(done), .issue(issue), .w_addr(w_addr),
        .d_addr(d_addr), .mode(mode), .acc_en(acc_en), .acc_clr(acc_clr),
        .acc_shift(acc_shift)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] w;
        logic [AW-1:0] d;
        logic [1:0]    m;
    } iss_t;
    typedef struct packed {
        logic          clr;
        logic [SW-1:0] sh;
    } acc_t;

    iss_t           exp_iss[$];
    acc_t           exp_acc[$];
    logic [AW-1:0]  obs_w[$], obs_d[$];
    logic [1:0]     obs_m[$];
    logic [SW-1:0]  obs_sh[$];
    int             n_chk = 0;
    int             n_fail = 0;
    int             clr_cnt, done_cnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    initial begin : monitor
        logic [LAT-1:0] hist;
        iss_t ei;
        acc_t ea;
        hist = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hist = '0;
            end else begin
                chk("acc_en_lat", 32'(acc_en), 32'(hist[LAT-1]));
                hist = (hist << 1) | LAT'(issue);
                if (issue) begin
                    obs_w.push_back(w_addr);
                    obs_d.push_back(d_addr);
                    obs_m.push_back(mode);
                    if (exp_iss.size() == 0) begin
                        chk("issue_extra", 32'd1, 32'd0);
                    end else begin
                        ei = exp_iss.pop_front();
                        chk("w_addr", 32'(w_addr), 32'(ei.w));
                        chk("d_addr", 32'(d_addr), 32'(ei.d));
                        chk("mode", 32'(mode), 32'(ei.m));
                    end
                end
                if (acc_en) begin
                    obs_sh.push_back(acc_shift);
                    if (acc_clr) clr_cnt++;
                    if (exp_acc.size() == 0) begin
                        chk("acc_extra", 32'd1, 32'd0);
                    end else begin
                        ea = exp_acc.pop_front();
                        chk("acc_clr", 32'(acc_clr), 32'(ea.clr));
                        chk("acc_shift", 32'(acc_shift), 32'(ea.sh));
                    end
                end
                if (done) done_cnt++;
            end
        end
    end

    task automatic push_model(input int wpi, input int api, input int ti, input bit ws,
                              input bit asg, input logic [AW-1:0] wb, input logic [AW-1:0] db);
        iss_t ei;
        acc_t ea;
        obs_w.delete(); obs_d.delete(); obs_m.delete(); obs_sh.delete();
        clr_cnt = 0;
        done_cnt = 0;
        for (int k = 0; k < ti; k++)
            for (int wi = wpi - 1; wi >= 0; wi--)
                for (int aj = api - 1; aj >= 0; aj--) begin
                    ei.w   = wb + AW'(k * wpi + wi);
                    ei.d   = db + AW'(k * api + aj);
                    ei.m   = {ws && (wi == wpi - 1), asg && (aj == api - 1)};
                    ea.clr = (k == 0) && (wi == wpi - 1) && (aj == api - 1);
                    ea.sh  = SW'(wi + 2 * aj);
                    exp_iss.push_back(ei);
                    exp_acc.push_back(ea);
                end
    endtask

    task automatic drive_start(input logic [PW-1:0] wp_v, input logic [PW-1:0] ap_v,
                               input logic [TW-1:0] t_v, input bit ws, input bit asg,
                               input logic [AW-1:0] wb, input logic [AW-1:0] db, input bit st);
        @(posedge clk); #1;
        start = 1'b1; wp = wp_v; ap = ap_v; tiles = t_v;
        wsigned = ws; asigned = asg; w_base = wb; d_base = db; stall = st;
    endtask

    task automatic run_job(input logic [PW-1:0] wp_v, input logic [PW-1:0] ap_v,
                           input logic [TW-1:0] t_v, input bit ws, input bit asg,
                           input logic [AW-1:0] wb, input logic [AW-1:0] db,
                           input logic [63:0] smask, input bit b2b);
        int n, seen, last, exp_done, done_c;
        n = int'(t_v) * int'(wp_v) * int'(ap_v);
        push_model(int'(wp_v), int'(ap_v), int'(t_v), ws, asg, wb, db);
        if (n == 0) begin
            exp_done = 1;
        end else begin
            seen = 0;
            last = 0;
            for (int c = 1; c < 300 && last == 0; c++) begin
                if (!(c < 64 && smask[c])) begin
                    seen++;
                    if (seen == n) last = c;
                end
            end
            exp_done = last + LAT + 1;
        end
        drive_start(wp_v, ap_v, t_v, ws, asg, wb, db, smask[0]);
        done_c = 0;
        for (int c = 1; c <= exp_done + 20 && done_c == 0; c++) begin
            @(posedge clk); #1;
            start = b2b && (c == exp_done);
            stall = (c < 64) ? smask[c] : 1'b0;
            @(negedge clk);
            chk("busy", 32'(busy), 32'(n != 0 && c < exp_done));
            if (done) done_c = c;
        end
        chk("done_cycle", 32'(done_c), 32'(exp_done));
        @(posedge clk); #1;
        start = 1'b0;
        stall = 1'b0;
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("idle_after_done", 32'({busy, issue}), 32'd0);
        chk("issues_left", 32'(exp_iss.size()), 32'd0);
        chk("accs_left", 32'(exp_acc.size()), 32'd0);
        chk("clr_count", 32'(clr_cnt), 32'(n != 0));
        chk("done_count", 32'(done_cnt), 32'd1);
    endtask

    initial begin : stim
        logic [AW-1:0] ew2[8], ed2[8], ew7[4];
        logic [SW-1:0] es2[8];
        logic [1:0]    em2[8];
        ew2 = '{10'd1, 10'd1, 10'd0, 10'd0, 10'd3, 10'd3, 10'd2, 10'd2};
        ed2 = '{10'd1, 10'd0, 10'd1, 10'd0, 10'd3, 10'd2, 10'd3, 10'd2};
        es2 = '{9'd3, 9'd1, 9'd2, 9'd0, 9'd3, 9'd1, 9'd2, 9'd0};
        em2 = '{2'b11, 2'b10, 2'b01, 2'b00, 2'b11, 2'b10, 2'b01, 2'b00};
        ew7 = '{10'd1, 10'd0, 10'd1023, 10'd1022};

        rst_n = 1'b0; start = 1'b0; stall = 1'b0; wp = '0; ap = '0; tiles = '0;
        wsigned = 1'b0; asigned = 1'b0; w_base = '0; d_base = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ctl", 32'({busy, done, issue, acc_en, acc_clr}), 32'd0);
        chk("reset_dat", 32'({w_addr, d_addr, mode, acc_shift}), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);

        // single step; start held through the done cycle must be ignored
        run_job(4'd1, 4'd1, 8'd1, 1'b0, 1'b0, 10'd5, 10'd9, 64'd0, 1'b1);

        // 2x2x2 signed job, then the same job with a two-cycle stall
        for (int pass = 0; pass < 2; pass++) begin
            run_job(4'd2, 4'd2, 8'd2, 1'b1, 1'b1, 10'd0, 10'd0,
                    (pass == 1) ? 64'h18 : 64'd0, 1'b0);
            chk("seq_len", 32'(obs_w.size()), 32'd8);
            for (int i = 0; i < 8 && i < obs_w.size(); i++) begin
                chk("w_seq", 32'(obs_w[i]), 32'(ew2[i]));
                chk("d_seq", 32'(obs_d[i]), 32'(ed2[i]));
                chk("m_seq", 32'(obs_m[i]), 32'(em2[i]));
            end
            for (int i = 0; i < 8 && i < obs_sh.size(); i++)
                chk("shift_seq", 32'(obs_sh[i]), 32'(es2[i]));
        end

        // empty jobs
        run_job(4'd2, 4'd2, 8'd0, 1'b0, 1'b0, 10'd0, 10'd0, 64'd0, 1'b0);
        run_job(4'd0, 4'd3, 8'd4, 1'b1, 1'b1, 10'd7, 10'd7, 64'd0, 1'b0);

        // abandon a job after three issues
        push_model(2, 2, 2, 1'b1, 1'b1, 10'd0, 10'd0);
        drive_start(4'd2, 4'd2, 8'd2, 1'b1, 1'b1, 10'd0, 10'd0, 1'b0);
        for (int c = 1; c <= 3; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            @(negedge clk);
        end
        chk("pre_reset_issues", 32'(obs_w.size()), 32'd3);
        @(posedge clk); #1;
        rst_n = 1'b0;
        exp_iss.delete();
        exp_acc.delete();
        #1;
        chk("midrst_ctl", 32'({busy, done, issue, acc_en, acc_clr}), 32'd0);
        chk("midrst_dat", 32'({w_addr, d_addr, mode, acc_shift}), 32'd0);
        done_cnt = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("post_reset_idle", 32'({busy, done, issue, acc_en}), 32'd0);
        end
        chk("post_reset_done", 32'(done_cnt), 32'd0);
        run_job(4'd1, 4'd1, 8'd1, 1'b0, 1'b0, 10'd0, 10'd0, 64'd0, 1'b0);

        // address wrap modulo 2^AW
        run_job(4'd4, 4'd1, 8'd1, 1'b1, 1'b0, 10'd1022, 10'd100, 64'd0, 1'b0);
        chk("wrap_len", 32'(obs_w.size()), 32'd4);
        for (int i = 0; i < 4 && i < obs_w.size(); i++)
            chk("wrap_seq", 32'(obs_w[i]), 32'(ew7[i]));

        // larger job with random stalls and random bases
        run_job(4'd3, 4'd3, 8'd3, 1'b1, 1'b0, AW'($urandom), AW'($urandom),
                {$urandom, $urandom}, 1'b0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1);
    end
endmodule
